// File: rtl/boton_pulsos.sv
// Push-button front end: two-flop synchronizer, counter-based debouncer and a
// press classifier that emits single-cycle press / short / long pulses for the
// stopwatch controls (press toggles run/stop, long press clears).
module boton_pulsos #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  logic          s1;
  logic          s2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  state_t        state;

  // The debounced level flips on the edge where the disagreement run completes;
  // the classifier sees that same edge so press_pulse lines up with pressed.
  logic flip;
  logic rise;
  logic fall;

  assign flip = (s2 != pressed) && (deb_cnt == DEB_LAST);
  assign rise = flip & s2;
  assign fall = flip & ~s2;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debouncer: count consecutive edges where s2 disagrees with pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      pressed <= 1'b0;
    end else if (s2 == pressed) begin
      deb_cnt <= '0;
    end else if (flip) begin
      deb_cnt <= '0;
      pressed <= s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Press classifier with registered single-cycle pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state       <= PRESS;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        PRESS: begin
          hold_cnt <= hold_cnt + 1'b1;
          // Release takes priority over the hold count completing.
          if (fall) begin
            short_pulse <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_pulse <= 1'b1;
            state      <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          // Hold counter stays frozen here; release returns silently.
          if (fall) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
